// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter. It drives the select of an internal bus mux that
// shares one valid/ready output channel among 2**SEL_WIDTH requesters. A grant
// is held until the beat carrying lst is accepted. The grant is also released
// when MAX_BEATS beats have been accepted.
// Optional feature: define MUX_RR_ARBITER_GNT_CNT_EN to add per-requester
// saturating grant counters on gnt_cnt_o.
module mux_rr_arbiter #(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned DAT_WIDTH = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [(1<<SEL_WIDTH)-1:0]                   req_vld_i,
  input  logic [(1<<SEL_WIDTH)-1:0][DAT_WIDTH-1:0]    req_dat_i,
  input  logic [(1<<SEL_WIDTH)-1:0]                   req_lst_i,
  output logic [(1<<SEL_WIDTH)-1:0]                   req_rdy_o,
  output logic                                        vld_o,
  output logic [DAT_WIDTH-1:0]                        dat_o,
  output logic                                        lst_o,
  input  logic                                        rdy_i,
  output logic [SEL_WIDTH-1:0]                        sel_o,
`ifdef MUX_RR_ARBITER_GNT_CNT_EN
  output logic [(1<<SEL_WIDTH)-1:0][15:0]             gnt_cnt_o,
`endif
  output logic                                        busy_o
);

  localparam int unsigned N     = 1 << SEL_WIDTH;
  localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [SEL_WIDTH-1:0] winner;
  logic [SEL_WIDTH-1:0] idx;
  logic                 any_req;
  logic                 busy;
  logic                 grant;
  logic                 accept;
  logic                 cnt_full;
  logic                 mux_vld;
  logic                 mux_lst;
  logic [DAT_WIDTH-1:0] mux_dat;

  // Bus mux: route the selected requester's beat to the output channel.
  always_comb begin
    mux_vld = req_vld_i[sel_q];
    mux_dat = req_dat_i[sel_q];
    mux_lst = req_lst_i[sel_q];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    winner  = last_gnt_q;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      // SEL_WIDTH-bit addition wraps modulo N
      idx = last_gnt_q + SEL_WIDTH'(i);
      if (!any_req && req_vld_i[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // Output channel and per-requester ready, all gated by the grant.
  always_comb begin
    busy     = (state_q == StBusy);
    cnt_full = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    busy_o   = busy;
    sel_o    = sel_q;
    vld_o    = busy & mux_vld;
    dat_o    = mux_dat;
    lst_o    = busy & (mux_lst | cnt_full);
    req_rdy_o = '0;
    if (busy) begin
      req_rdy_o[sel_q] = rdy_i;
    end
    accept = vld_o & rdy_i;
    grant  = (state_q == StIdle) & any_req;
  end

  // Next-state: grant in IDLE, count beats in BUSY, release on last beat.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          sel_d      = winner;
          state_d    = StBusy;
          beat_cnt_d = '0;
        end
      end
      default: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (lst_o) begin
            state_d    = StIdle;
            last_gnt_d = sel_q;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      last_gnt_q <= SEL_WIDTH'(N - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef MUX_RR_ARBITER_GNT_CNT_EN
  logic [N-1:0][15:0] gnt_cnt_q, gnt_cnt_d;

  // Saturating per-requester grant counters, bumped on each IDLE->BUSY.
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant && (winner == SEL_WIDTH'(i)) && (gnt_cnt_q[i] != 16'hFFFF)) begin
        gnt_cnt_d[i] = gnt_cnt_q[i] + 16'd1;
      end
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt_o = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (SEL_WIDTH=2, DAT_WIDTH=8, MAX_BEATS=4).
module tb_mux_rr_arbiter;

  localparam int SW   = 2;
  localparam int N    = 1 << SW;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req_vld;
  logic [N-1:0][DW-1:0]   req_dat;
  logic [N-1:0]           req_lst;
  logic [N-1:0]           req_rdy_o;
  logic                   vld_o;
  logic [DW-1:0]          dat_o;
  logic                   lst_o;
  logic                   rdy;
  logic [SW-1:0]          sel_o;
  logic                   busy_o;
`ifdef MUX_RR_ARBITER_GNT_CNT_EN
  logic [N-1:0][15:0]     gnt_cnt;
`endif

  mux_rr_arbiter #(
    .SEL_WIDTH(SW),
    .DAT_WIDTH(DW),
    .MAX_BEATS(MAXB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld_i(req_vld),
    .req_dat_i(req_dat),
    .req_lst_i(req_lst),
    .req_rdy_o(req_rdy_o),
    .vld_o    (vld_o),
    .dat_o    (dat_o),
    .lst_o    (lst_o),
    .rdy_i    (rdy),
    .sel_o    (sel_o),
`ifdef MUX_RR_ARBITER_GNT_CNT_EN
    .gnt_cnt_o(gnt_cnt),
`endif
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: packet-level view kept as plain integers.
  bit m_busy;
  int m_sel;
  int m_last;
  int m_beats;
  int m_gcnt[N];
  bit e_vld;
  bit e_lst;

  typedef struct {
    logic [N-1:0] lst;
    int           sel;
    logic         busy;
    logic         lsto;
  } vec_t;
  vec_t tbl[16];

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy  = 0;
    m_sel   = 0;
    m_last  = N - 1;
    m_beats = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endfunction

  function automatic logic [N-1:0][DW-1:0] rnd_dat();
    logic [N-1:0][DW-1:0] d;
    for (int i = 0; i < N; i++) d[i] = DW'($urandom);
    return d;
  endfunction

  // Apply one cycle of inputs and compare every output against the model.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                       input logic rn, input logic [N-1:0][DW-1:0] d);
    logic [N-1:0] e_rdy;
    req_vld = v;
    req_lst = l;
    rdy     = r;
    rst_n   = rn;
    req_dat = d;
    #1;
    e_vld = m_busy && v[m_sel];
    e_lst = m_busy && (l[m_sel] || (m_beats == MAXB - 1));
    e_rdy = '0;
    if (m_busy) e_rdy[m_sel] = r;
    chk("busy_o", busy_o, m_busy);
    chk("sel_o", sel_o, m_sel);
    chk("vld_o", vld_o, e_vld);
    chk("lst_o", lst_o, e_lst);
    chk("req_rdy_o", req_rdy_o, e_rdy);
    if (e_vld) chk("dat_o", dat_o, d[m_sel]);
`ifdef MUX_RR_ARBITER_GNT_CNT_EN
    for (int i = 0; i < N; i++) chk("gnt_cnt_o", gnt_cnt[i], m_gcnt[i]);
`endif
  endtask

  // Advance the model with the applied inputs, then clock the DUT.
  task automatic tick();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (req_vld != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req_vld[(m_last + k) % N]) w = (m_last + k) % N;
        end
        m_sel   = w;
        m_busy  = 1;
        m_beats = 0;
        if (m_gcnt[w] < 65535) m_gcnt[w]++;
      end
    end else if (e_vld && rdy) begin
      m_beats++;
      if (e_lst) begin
        m_busy = 0;
        m_last = m_sel;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                       input logic rn);
    drive(v, l, r, rn, rnd_dat());
    tick();
  endtask

  initial begin
    int b;
    int grants;
    int k;
    bit prev_busy;
    int lst_beats[$];
    logic [7:0] rx[$];
    logic [N-1:0][DW-1:0] d;
    logic r_pat [8];

    // Round-robin over four requesters with 2-beat packets.
    tbl[0]  = '{4'h0, 0, 1'b0, 1'b0};
    tbl[1]  = '{4'h0, 0, 1'b1, 1'b0};
    tbl[2]  = '{4'hF, 0, 1'b1, 1'b1};
    tbl[3]  = '{4'h0, 0, 1'b0, 1'b0};
    tbl[4]  = '{4'h0, 1, 1'b1, 1'b0};
    tbl[5]  = '{4'hF, 1, 1'b1, 1'b1};
    tbl[6]  = '{4'h0, 1, 1'b0, 1'b0};
    tbl[7]  = '{4'h0, 2, 1'b1, 1'b0};
    tbl[8]  = '{4'hF, 2, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 2, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 3, 1'b1, 1'b0};
    tbl[11] = '{4'hF, 3, 1'b1, 1'b1};
    tbl[12] = '{4'h0, 3, 1'b0, 1'b0};
    tbl[13] = '{4'h0, 0, 1'b1, 1'b0};
    tbl[14] = '{4'hF, 0, 1'b1, 1'b1};
    tbl[15] = '{4'h0, 0, 1'b0, 1'b0};

    rst_n   = 1'b0;
    req_vld = '0;
    req_lst = '0;
    req_dat = '0;
    rdy     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_vld", vld_o, 0);
    chk("rst_lst", lst_o, 0);
    chk("rst_rdy", req_rdy_o, 0);

    // Table-driven round-robin sequence.
    for (int i = 0; i < 16; i++) begin
      drive(4'hF, tbl[i].lst, 1'b1, 1'b1, rnd_dat());
      chk("t1_sel", sel_o, tbl[i].sel);
      chk("t1_busy", busy_o, tbl[i].busy);
      chk("t1_lst", lst_o, tbl[i].lsto);
      tick();
    end

    // Only requester 2, three 3-beat packets.
    cycle('0, '0, 1'b1, 1'b0);
    b = 0;
    grants = 0;
    prev_busy = 0;
    for (int c = 0; c < 12; c++) begin
      drive(4'b0100, (b == 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b1, rnd_dat());
      if (busy_o && !prev_busy) grants++;
      prev_busy = busy_o;
      if (vld_o) begin
        chk("t2_sel", sel_o, 2);
        chk("t2_lst", lst_o, (b == 2));
        chk("t2_dat", dat_o, req_dat[2]);
        b = (b == 2) ? 0 : b + 1;
      end
      tick();
    end
    chk("t2_grants", grants, 3);

    // Forced release every MAXB beats; lst never set by requester 1.
    cycle('0, '0, 1'b1, 1'b0);
    b = 0;
    grants = 0;
    prev_busy = 0;
    for (int c = 0; c < 13; c++) begin
      drive((b < 10) ? 4'b0010 : 4'b0000, '0, 1'b1, 1'b1, rnd_dat());
      if (busy_o && !prev_busy) grants++;
      prev_busy = busy_o;
      if (vld_o && rdy) begin
        b++;
        if (lst_o) lst_beats.push_back(b);
      end
      tick();
    end
    chk("t3_grants", grants, 3);
    chk("t3_nlst", lst_beats.size(), 2);
    if (lst_beats.size() == 2) begin
      chk("t3_lst_a", lst_beats[0], 4);
      chk("t3_lst_b", lst_beats[1], 8);
    end
    // Granted source stalls; requester 3 must wait.
    for (int c = 0; c < 3; c++) begin
      drive(4'b1000, '0, 1'b1, 1'b1, rnd_dat());
      chk("t3_hold_busy", busy_o, 1);
      chk("t3_hold_sel", sel_o, 1);
      chk("t3_hold_rdy3", req_rdy_o[3], 0);
      tick();
    end
    cycle(4'b1010, 4'b0010, 1'b1, 1'b1);
    cycle(4'b1010, 4'b0000, 1'b1, 1'b1);
    chk("t3_next_sel", sel_o, 3);

    // Downstream backpressure: data neither lost nor duplicated.
    cycle('0, '0, 1'b1, 1'b0);
    r_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      d = rnd_dat();
      d[0] = 8'hA0 + 8'(k);
      drive((k < 4) ? 4'b0001 : 4'b0000, (k == 3) ? 4'b0001 : 4'b0000, r_pat[c], 1'b1, d);
      if (busy_o) chk("t4_rdy0", req_rdy_o[0], r_pat[c]);
      if (vld_o && rdy) begin
        rx.push_back(dat_o);
        k++;
      end
      tick();
    end
    chk("t4_nrx", rx.size(), 4);
    for (int j = 0; j < rx.size() && j < 4; j++) chk("t4_rx", rx[j], 8'hA0 + j);

    // Reset mid-packet on beat 2 of 4.
    cycle('0, '0, 1'b1, 1'b0);
    cycle(4'b0100, '0, 1'b1, 1'b1);
    cycle(4'b0100, '0, 1'b1, 1'b1);
    cycle(4'b0100, '0, 1'b1, 1'b0);
    drive(4'b0101, '0, 1'b1, 1'b1, rnd_dat());
    chk("t5_busy", busy_o, 0);
    chk("t5_sel", sel_o, 0);
    chk("t5_vld", vld_o, 0);
    tick();
    drive(4'b0101, '0, 1'b1, 1'b1, rnd_dat());
    chk("t5_gnt_sel", sel_o, 0);
    chk("t5_gnt_busy", busy_o, 1);
    tick();

`ifdef MUX_RR_ARBITER_GNT_CNT_EN
    // Five round-robin rounds of 2-beat packets.
    cycle('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) chk("t6_cnt_rst", gnt_cnt[i], 0);
    for (int c = 0; c < 60; c++) cycle(4'hF, ((c % 3) == 2) ? 4'hF : 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) chk("t6_cnt5", gnt_cnt[i], 5);
`endif

    // Randomized traffic against the model.
    cycle('0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 500; c++) begin
      cycle(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(99) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
